// File: rtl/tnn_feature_sequencer.sv
// Quantizes a stream of raw feature samples into five 2-bit lanes for a combinational
// classifier core, holds the lanes while the core settles, and returns one class bit per frame.
module tnn_feature_sequencer #(
    parameter int unsigned RAW_W       = 8,
    parameter int unsigned TH0         = 64,
    parameter int unsigned TH1         = 128,
    parameter int unsigned TH2         = 192,
    parameter int unsigned EVAL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [RAW_W-1:0] s_data_i,
    input  logic             s_last_i,
    output logic [1:0]       input_a_o,
    output logic [1:0]       input_b_o,
    output logic [1:0]       input_c_o,
    output logic [1:0]       input_d_o,
    output logic [1:0]       input_e_o,
    input  logic             cgp_out_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_class_o,
    output logic             m_err_o
);

    localparam int unsigned CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVAL_CYCLES - 1);
    localparam logic [RAW_W-1:0] TH0_C = RAW_W'(TH0);
    localparam logic [RAW_W-1:0] TH1_C = RAW_W'(TH1);
    localparam logic [RAW_W-1:0] TH2_C = RAW_W'(TH2);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EVAL  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       lane_q [5];
    logic [1:0]       lane_d [5];
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic             m_class_q, m_class_d;
    logic             m_err_q, m_err_d;
    logic             beat_s;
    logic             last_lane_s;

    function automatic logic [1:0] quant_f(input logic [RAW_W-1:0] x);
        logic [1:0] q;
        if (x >= TH2_C) begin
            q = 2'd3;
        end else if (x >= TH1_C) begin
            q = 2'd2;
        end else if (x >= TH0_C) begin
            q = 2'd1;
        end else begin
            q = 2'd0;
        end
        return q;
    endfunction

    assign beat_s      = s_valid_i & s_ready_q;
    assign last_lane_s = (idx_q == 3'd4);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (beat_s && last_lane_s) begin
                    state_d = s_last_i ? ST_EVAL : ST_DRAIN;
                end else if (beat_s && s_last_i) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (beat_s && s_last_i) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_EVAL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            ST_OUT: begin
                if (m_valid_q && m_ready_i) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        idx_d     = idx_q;
        err_d     = err_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        m_err_d   = m_err_q;
        cnt_d     = (state_q == ST_EVAL) ? (cnt_q + CNT_W'(1)) : '0;
        s_ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        for (int j = 0; j < 5; j++) begin
            lane_d[j] = lane_q[j];
        end
        case (state_q)
            ST_LOAD: begin
                if (beat_s) begin
                    // A short frame clears the lanes it never reached so no stale feature leaks in.
                    for (int j = 0; j < 5; j++) begin
                        if (3'(j) == idx_q) begin
                            lane_d[j] = quant_f(s_data_i);
                        end else if (s_last_i && (3'(j) > idx_q)) begin
                            lane_d[j] = 2'b00;
                        end else begin
                            lane_d[j] = lane_q[j];
                        end
                    end
                    if (last_lane_s) begin
                        err_d = err_q | ~s_last_i;
                        idx_d = idx_q;
                    end else if (s_last_i) begin
                        err_d = 1'b1;
                        idx_d = idx_q;
                    end else begin
                        err_d = err_q;
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DRAIN: begin
                err_d = err_q;
            end
            ST_EVAL: begin
                if (cnt_q == CNT_LAST) begin
                    m_class_d = cgp_out_i;
                    m_err_d   = err_q;
                    m_valid_d = 1'b1;
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
            ST_OUT: begin
                if (m_valid_q && m_ready_i) begin
                    m_valid_d = 1'b0;
                    idx_d     = 3'd0;
                    err_d     = 1'b0;
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
            default: begin
                idx_d = 3'd0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= 3'd0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_class_q <= 1'b0;
            m_err_q   <= 1'b0;
            for (int j = 0; j < 5; j++) begin
                lane_q[j] <= 2'b00;
            end
        end else begin
            idx_q     <= idx_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
            m_err_q   <= m_err_d;
            for (int j = 0; j < 5; j++) begin
                lane_q[j] <= lane_d[j];
            end
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_class_o = m_class_q;
    assign m_err_o   = m_err_q;
    assign input_a_o = lane_q[0];
    assign input_b_o = lane_q[1];
    assign input_c_o = lane_q[2];
    assign input_d_o = lane_q[3];
    assign input_e_o = lane_q[4];

endmodule
